// File: rtl/csa_stream_accumulator.sv
// Carry-save stream accumulator: sums a packet of narrow operands in redundant form,
// then resolves to binary. Define CSA_ACC_OVF_EN to compile the sticky overflow flag.
module csa_stream_accumulator #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned ACC_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    if (ACC_W < WIDTH + 1) begin : g_width_check
        $error("ACC_W must be at least WIDTH+1");
    end

    typedef enum logic [1:0] {StAccum, StResolve, StOutput} state_e;

    state_e state_q, state_d;

    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic [ACC_W-1:0] x_ext;
    logic [ACC_W-1:0] maj_acc;
    logic [ACC_W-1:0] and_res;
    logic [CNT_W-1:0] cnt_inc;
    logic             c_zero;

    assign x_ext   = ACC_W'(in_data);
    assign maj_acc = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);
    assign and_res = s_q & c_q;
    assign c_zero  = (c_q == '0);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: begin
                if (in_valid && in_last) begin
                    state_d = StResolve;
                end
            end
            StResolve: begin
                if (c_zero) begin
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (out_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // Handshake outputs depend on state only, so no out_ready -> in_ready path exists
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StOutput);
    end

`ifdef CSA_ACC_OVF_EN
    logic ovf_q, ovf_d;
    logic out_ovf_q, out_ovf_d;
`endif

    always_comb begin
        s_d        = s_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_cnt_d  = out_cnt_q;
`ifdef CSA_ACC_OVF_EN
        ovf_d      = ovf_q;
        out_ovf_d  = out_ovf_q;
`endif
        unique case (state_q)
            StAccum: begin
                if (in_valid) begin
                    s_d   = s_q ^ c_q ^ x_ext;
                    c_d   = maj_acc << 1;
                    cnt_d = cnt_inc;
`ifdef CSA_ACC_OVF_EN
                    ovf_d = ovf_q | maj_acc[ACC_W-1];
`endif
                end
            end
            StResolve: begin
                if (c_zero) begin
                    out_data_d = s_q;
                    out_cnt_d  = cnt_q;
`ifdef CSA_ACC_OVF_EN
                    out_ovf_d  = ovf_q;
`endif
                end else begin
                    s_d = s_q ^ c_q;
                    c_d = and_res << 1;
`ifdef CSA_ACC_OVF_EN
                    ovf_d = ovf_q | and_res[ACC_W-1];
`endif
                end
            end
            StOutput: begin
                if (out_ready) begin
                    s_d   = '0;
                    c_d   = '0;
                    cnt_d = '0;
`ifdef CSA_ACC_OVF_EN
                    ovf_d = 1'b0;
`endif
                end
            end
            default: begin
                s_d   = '0;
                c_d   = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= '0;
            c_q        <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            s_q        <= s_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

`ifdef CSA_ACC_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_data = out_data_q;
    assign out_cnt  = out_cnt_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed self-checking bench for csa_stream_accumulator (default WIDTH=3, ACC_W=8, CNT_W=8).
module tb_csa_stream_accumulator;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned CNT_W = 8;

`ifdef CSA_ACC_OVF_EN
    localparam logic OVF_WRAP = 1'b1;
`else
    localparam logic OVF_WRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    csa_stream_accumulator #(
        .WIDTH(WIDTH),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_cnt  (out_cnt),
        .out_ovf  (out_ovf)
    );

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Waits for out_valid with a cycle budget; in_ready must stay low meanwhile.
    task automatic wait_out(input int budget, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < budget) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_ready: in_ready=%b required 0 at wait cycle %0d", in_ready, lat);
            end
            tick();
            lat++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL out_timeout: out_valid=%b required 1 within %0d cycles", out_valid, budget);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [ACC_W-1:0] exp_data,
                                input logic [CNT_W-1:0] exp_cnt, input logic exp_ovf);
        vectors++;
        if (out_data !== exp_data || out_cnt !== exp_cnt || out_ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s: data=%0d cnt=%0d ovf=%b required data=%0d cnt=%0d ovf=%b",
                     name, out_data, out_cnt, out_ovf, exp_data, exp_cnt, exp_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        check_result("reset_outs", 8'd0, 8'd0, 1'b0);
    endtask

    task automatic test_single();
        send(3'd5, 1'b1);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_lat1: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_lat2: out_valid=%b required 1", out_valid);
        end
        check_result("single", 8'd5, 8'd1, 1'b0);
        handshake();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_release: out_valid=%b in_ready=%b required 0 1",
                     out_valid, in_ready);
        end
        check_result("single_retain", 8'd5, 8'd1, 1'b0);
    endtask

    task automatic test_multi();
        int lat;
        send(3'd7, 1'b0);
        send(3'd7, 1'b0);
        send(3'd7, 1'b1);
        wait_out(ACC_W + 1, lat);
        check_result("multi_777", 8'd21, 8'd3, 1'b0);
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        send(3'd4, 1'b0);
        send(3'd6, 1'b1);
        wait_out(ACC_W + 1, lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_hs: cycle %0d out_valid=%b in_ready=%b required 1 0",
                         i, out_valid, in_ready);
            end
            check_result("bp_hold", 8'd10, 8'd2, 1'b0);
        end
        handshake();
        send(3'd1, 1'b0);
        send(3'd2, 1'b1);
        wait_out(ACC_W + 1, lat);
        check_result("bp_next", 8'd3, 8'd2, 1'b0);
        handshake();
    endtask

    task automatic test_wrap();
        int lat;
        for (int i = 0; i < 36; i++) begin
            send(3'd7, 1'b0);
        end
        send(3'd7, 1'b1);
        // send() already consumed the capture edge, so ACC_W+1 more fit the bound
        wait_out(ACC_W + 1, lat);
        vectors++;
        if (lat > ACC_W + 1) begin
            miscompares++;
            $display("FAIL wrap_latency: %0d cycles required <= %0d", lat + 1, ACC_W + 2);
        end
        check_result("wrap", 8'd3, 8'd37, OVF_WRAP);
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        send(3'd2, 1'b0);
        send(3'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(3'd4, 1'b1);
        wait_out(ACC_W + 1, lat);
        check_result("rst_accum", 8'd4, 8'd1, 1'b0);
        handshake();
        // 7,7,7 leaves C nonzero, so the state is still RESOLVE when rst hits
        send(3'd7, 1'b0);
        send(3'd7, 1'b0);
        send(3'd7, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_result("rst_resolve_clr", 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < ACC_W + 4; i++) begin
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_resolve_abort: cycle %0d out_valid=%b in_ready=%b required 0 1",
                         i, out_valid, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_gapped();
        int lat;
        send(3'd1, 1'b0);
        // Idle cycles carry junk data and in_last without in_valid
        in_data = 3'd7;
        in_last = 1'b1;
        tick();
        in_data = '0;
        in_last = 1'b0;
        send(3'd6, 1'b0);
        in_data = 3'd5;
        in_last = 1'b1;
        tick();
        tick();
        in_data = '0;
        in_last = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        send(3'd3, 1'b1);
        wait_out(ACC_W + 1, lat);
        check_result("gapped", 8'd10, 8'd3, 1'b0);
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_gapped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
